// File: rtl/sccb_target.sv
// SCCB (3-wire-compatible, 2-wire) register target.
// Decodes START/STOP and the ID / sub-address / data phases on an oversampled SIO_C/SIO_D pair.
// Issues one-cycle write strobes and read requests, and drives SIO_D open-drain (low or released).
module sccb_target #(
    parameter logic [7:0] DeviceAddress = 8'h42,
    parameter int         SyncStages    = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_sio_c,
    inout  wire        io_sio_d,
    output logic [7:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_wr_valid,
    output logic       o_rd_req,
    input  logic [7:0] i_rdata,
    output logic       o_busy
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID_BYTE   = 4'd1,
        ST_ID_ACK    = 4'd2,
        ST_SUB_BYTE  = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_DATA_BYTE = 4'd5,
        ST_DATA_ACK  = 4'd6,
        ST_READ_BYTE = 4'd7,
        ST_READ_NA   = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_e;

    state_e                state_q, state_d;
    logic [SyncStages-1:0] sioc_sync_q, sioc_sync_d;
    logic [SyncStages-1:0] siod_sync_q, siod_sync_d;
    logic                  sioc_prev_q, siod_prev_q;
    logic [2:0]            cnt_q, cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  rw_q, rw_d;
    logic                  sda_oe_q, sda_oe_d;
    logic [7:0]            addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  wr_valid_q, wr_valid_d;
    logic                  rd_req_q, rd_req_d;
    logic                  rd_load_q, rd_load_d;
    logic                  busy_q, busy_d;

    logic       sioc_s, siod_s;
    logic       scl_rise_s, scl_fall_s, start_s, stop_s, last_bit_s;
    logic [7:0] byte_s;

    // Synchronizer shift chains: stage 0 takes the raw pin, each later stage copies the previous one.
    always_comb begin
        sioc_sync_d    = sioc_sync_q;
        siod_sync_d    = siod_sync_q;
        sioc_sync_d[0] = i_sio_c;
        siod_sync_d[0] = io_sio_d;
        for (int i = 1; i < SyncStages; i++) begin
            sioc_sync_d[i] = sioc_sync_q[i-1];
            siod_sync_d[i] = siod_sync_q[i-1];
        end
    end

    assign sioc_s     = sioc_sync_q[SyncStages-1];
    assign siod_s     = siod_sync_q[SyncStages-1];
    assign scl_rise_s = sioc_s & ~sioc_prev_q;
    assign scl_fall_s = ~sioc_s & sioc_prev_q;
    // START/STOP need SIO_C high on both samples so a data change racing a clock edge is not misread.
    assign start_s    = sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
    assign stop_s     = sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;
    assign last_bit_s = (cnt_q == 3'd0);
    assign byte_s     = {shift_q[6:0], siod_s};

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; START and STOP override every state.
    always_comb begin
        state_d = state_q;
        if (start_s) begin
            state_d = ST_ID_BYTE;
        end else if (stop_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_IDLE;
                ST_ID_BYTE: begin
                    if (scl_rise_s && last_bit_s) begin
                        state_d = (byte_s[7:1] == DeviceAddress[7:1]) ? ST_ID_ACK : ST_WAIT_STOP;
                    end else begin
                        state_d = ST_ID_BYTE;
                    end
                end
                ST_ID_ACK: begin
                    if (scl_fall_s && sda_oe_q) begin
                        state_d = rw_q ? ST_READ_BYTE : ST_SUB_BYTE;
                    end else begin
                        state_d = ST_ID_ACK;
                    end
                end
                ST_SUB_BYTE:  state_d = (scl_rise_s && last_bit_s) ? ST_SUB_ACK   : ST_SUB_BYTE;
                ST_SUB_ACK:   state_d = (scl_fall_s && sda_oe_q)   ? ST_DATA_BYTE : ST_SUB_ACK;
                ST_DATA_BYTE: state_d = (scl_rise_s && last_bit_s) ? ST_DATA_ACK  : ST_DATA_BYTE;
                ST_DATA_ACK:  state_d = (scl_fall_s && sda_oe_q)   ? ST_WAIT_STOP : ST_DATA_ACK;
                ST_READ_BYTE: state_d = (scl_fall_s && last_bit_s && !rd_load_q) ? ST_READ_NA : ST_READ_BYTE;
                ST_READ_NA:   state_d = scl_rise_s ? ST_WAIT_STOP : ST_READ_NA;
                ST_WAIT_STOP: state_d = ST_WAIT_STOP;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values: bit shifting, ACK/read-bit drive, address/data capture, strobes.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        rd_load_d  = rd_req_q;
        busy_d     = (state_d != ST_IDLE);
        if (start_s || stop_s) begin
            cnt_d    = 3'd7;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_ID_BYTE, ST_SUB_BYTE, ST_DATA_BYTE: begin
                    if (scl_rise_s) begin
                        shift_d = byte_s;
                        cnt_d   = cnt_q - 3'd1;
                        if (!last_bit_s) begin
                            rw_d = rw_q;
                        end else if (state_q == ST_ID_BYTE) begin
                            rw_d = byte_s[0];
                        end else if (state_q == ST_SUB_BYTE) begin
                            addr_d = byte_s;
                        end else begin
                            data_d     = byte_s;
                            wr_valid_d = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                ST_ID_ACK, ST_SUB_ACK, ST_DATA_ACK: begin
                    // First falling edge after the 8th bit pulls low, the next one releases.
                    if (scl_fall_s) begin
                        sda_oe_d = ~sda_oe_q;
                        rd_req_d = sda_oe_q && rw_q && (state_q == ST_ID_ACK);
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                ST_READ_BYTE: begin
                    // MSB goes out as soon as the read data lands, while SIO_C is still low.
                    if (rd_load_q) begin
                        shift_d  = i_rdata;
                        cnt_d    = 3'd7;
                        sda_oe_d = ~i_rdata[7];
                    end else if (scl_fall_s) begin
                        if (last_bit_s) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            cnt_d    = cnt_q - 3'd1;
                            sda_oe_d = ~shift_q[6];
                        end
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    // Datapath registers, synchronizers and edge-detect history.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sioc_sync_q <= '1;
            siod_sync_q <= '1;
            sioc_prev_q <= 1'b1;
            siod_prev_q <= 1'b1;
            cnt_q       <= 3'd7;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            wr_valid_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_load_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sioc_sync_q <= sioc_sync_d;
            siod_sync_q <= siod_sync_d;
            sioc_prev_q <= sioc_s;
            siod_prev_q <= siod_s;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_valid_q  <= wr_valid_d;
            rd_req_q    <= rd_req_d;
            rd_load_q   <= rd_load_d;
            busy_q      <= busy_d;
        end
    end

    assign io_sio_d   = sda_oe_q ? 1'b0 : 1'bz;
    assign o_addr     = addr_q;
    assign o_data     = data_q;
    assign o_wr_valid = wr_valid_q;
    assign o_rd_req   = rd_req_q;
    assign o_busy     = busy_q;

endmodule
